// File: rtl/key_debounce_pkg.sv
// Shared helpers for the key_debounce input-conditioning slice.
package key_debounce_pkg;

    // A debounce counter never shrinks below one bit, even for settle_cycles = 1.
    localparam int unsigned MIN_CNT_W = 1;

    // Convert a debounce window in milliseconds to clock cycles.
    function automatic int unsigned settle_from_ms(input int unsigned clk_mhz,
                                                   input int unsigned ms);
        return clk_mhz * 1000 * ms;
    endfunction

    // Width needed to hold counts 0 .. settle, never below MIN_CNT_W.
    function automatic int unsigned cnt_width(input int unsigned settle);
        int unsigned w;
        w = $clog2(settle + 1);
        return (w < MIN_CNT_W) ? MIN_CNT_W : w;
    endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// One debounce channel: polarity fix, two-flop synchroniser, stability
// counter, debounced level and registered press/release pulses.
module debounce_bit
    import key_debounce_pkg::*;
#(
    parameter int unsigned settle_cycles = 4,
    parameter bit          active_low    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic pressed_o,
    output logic released_o
);

    localparam int unsigned          CNT_W    = cnt_width(settle_cycles);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(settle_cycles - 1);

    logic             norm;
    logic             sync1_q;
    logic             sync2_q;
    logic             level_q,    level_d;
    logic             pressed_q,  pressed_d;
    logic             released_q, released_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    // Normalise to active-high before the first synchroniser flop.
    assign norm = active_low ? ~raw_i : raw_i;

    // Synchroniser and debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            level_q    <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= norm;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            cnt_q      <= cnt_d;
        end
    end

    // Accept a new level only after settle_cycles consecutive disagreeing
    // samples; any agreeing sample restarts the window.
    always_comb begin
        cnt_d      = '0;
        level_d    = level_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d    = sync2_q;
                pressed_d  = sync2_q;
                released_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign level_o    = level_q;
    assign pressed_o  = pressed_q;
    assign released_o = released_q;

endmodule

// File: rtl/key_debounce.sv
// Input-conditioning stage: w_key independent debounce channels.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned clk_mhz       = 50,
    parameter int unsigned w_key         = 4,
    parameter int unsigned debounce_ms   = 10,
    parameter int unsigned settle_cycles = settle_from_ms(clk_mhz, debounce_ms),
    parameter bit          active_low    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [w_key-1:0] raw,
    output logic [w_key-1:0] level,
    output logic [w_key-1:0] pressed,
    output logic [w_key-1:0] released
);

    // One fully independent channel per input bit.
    for (genvar g = 0; g < int'(w_key); g++) begin : g_bit
        debounce_bit #(
            .settle_cycles (settle_cycles),
            .active_low    (active_low)
        ) u_bit (
            .clk        (clk),
            .rst        (rst),
            .raw_i      (raw[g]),
            .level_o    (level[g]),
            .pressed_o  (pressed[g]),
            .released_o (released[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce (w_key = 4, settle_cycles = 4, active low).
module tb_key_debounce;

    localparam int unsigned W = 4;
    localparam int unsigned S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] raw = '0;
    logic [W-1:0] level;
    logic [W-1:0] pressed;
    logic [W-1:0] released;

    always #5 clk = ~clk;

    key_debounce #(
        .w_key         (W),
        .settle_cycles (S),
        .active_low    (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .raw      (raw),
        .level    (level),
        .pressed  (pressed),
        .released (released)
    );

    typedef struct {
        int unsigned  at;
        logic [W-1:0] p;
        logic [W-1:0] r;
    } ev_t;

    ev_t          exp_q[$];
    int unsigned  cyc = 0;
    bit           done = 1'b0;
    int           n_checks = 0;
    int           n_pass = 0;

    // Reference model: input is seen two edges late; the level changes once the
    // last S observed samples since the previous change/reset all disagree with it.
    logic [W-1:0] m_s1 = '0;
    logic [W-1:0] m_s2 = '0;
    logic [W-1:0] m_lvl = '0;
    bit           hist [W][$];

    always @(posedge clk) begin
        logic [W-1:0] pm;
        logic [W-1:0] rm;
        bit           flip;
        cyc = cyc + 1;
        pm  = '0;
        rm  = '0;
        if (rst) begin
            m_s1  = '0;
            m_s2  = '0;
            m_lvl = '0;
            for (int b = 0; b < W; b++) hist[b].delete();
        end else begin
            for (int b = 0; b < W; b++) begin
                hist[b].push_back(m_s2[b]);
                if (hist[b].size() > S) void'(hist[b].pop_front());
                flip = (hist[b].size() == S);
                for (int k = 0; k < hist[b].size(); k++)
                    if (hist[b][k] == m_lvl[b]) flip = 1'b0;
                if (flip) begin
                    m_lvl[b] = ~m_lvl[b];
                    if (m_lvl[b]) pm[b] = 1'b1;
                    else          rm[b] = 1'b1;
                    hist[b].delete();
                end
            end
            m_s2 = m_s1;
            m_s1 = ~raw;
        end
        if ((pm | rm) != '0) exp_q.push_back('{cyc, pm, rm});
    end

    // Monitor: compares level every cycle and pops an expected event whenever
    // the DUT pulses or an expected event falls due.
    always @(negedge clk) begin
        ev_t e;
        if (done) begin
            n_checks++;
            if (exp_q.size() == 0) n_pass++;
            else $display("FAIL leftover_events: actual %0d pending, required 0", exp_q.size());
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $finish;
        end else begin
            n_checks++;
            if (level === m_lvl) n_pass++;
            else $display("FAIL level @%0d: actual %b, required %b", cyc, level, m_lvl);
            n_checks++;
            if ((pressed & released) === '0) n_pass++;
            else $display("FAIL pulse_overlap @%0d: pressed %b released %b, required no overlap",
                          cyc, pressed, released);
            if (pressed !== '0 || released !== '0 ||
                (exp_q.size() > 0 && exp_q[0].at == cyc)) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_pulse @%0d: pressed %b released %b, required none",
                             cyc, pressed, released);
                end else begin
                    e = exp_q.pop_front();
                    if (e.at == cyc && pressed === e.p && released === e.r) n_pass++;
                    else $display("FAIL pulse @%0d: pressed %b released %b, required @%0d pressed %b released %b",
                                  cyc, pressed, released, e.at, e.p, e.r);
                end
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with all keys held down, then release reset.
        rst = 1'b1;
        raw = 4'b0000;
        hold(3);
        rst = 1'b0;
        hold(12);
        raw = 4'b1111;
        hold(12);
        // Clean press and release of bit 0.
        raw[0] = 1'b0;
        hold(12);
        raw = 4'b1111;
        hold(12);
        // Bounce on bit 1: 3-cycle segments never settle.
        for (int i = 0; i < 10; i++) begin
            raw[1] = (i % 2 == 1) ? 1'b0 : 1'b1;
            hold(3);
        end
        raw[1] = 1'b1;
        hold(12);
        // Press then release bit 2.
        raw[2] = 1'b0;
        hold(12);
        raw[2] = 1'b1;
        hold(12);
        // Simultaneous press of bits 1 and 3.
        raw = 4'b0101;
        hold(12);
        raw = 4'b1111;
        hold(12);
        // Reset three edges into a press of bit 0.
        raw[0] = 1'b0;
        hold(3);
        rst = 1'b1;
        hold(1);
        rst = 1'b0;
        hold(12);
        raw = 4'b1111;
        hold(12);
        // Random bit flips with random hold times and occasional resets.
        for (int i = 0; i < 200; i++) begin
            raw = raw ^ W'($urandom_range(0, 15));
            hold(int'($urandom_range(1, 8)));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                hold(1);
                rst = 1'b0;
            end
        end
        raw = 4'b1111;
        hold(12);
        done = 1'b1;
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input-conditioning stage directly upstream of the lab `top` logic.
- Takes raw asynchronous board inputs (`key`, `sw`-style buses) and synchronises each bit to `clk`.
- Debounces each bit and normalises its polarity.
- Outputs a clean level bus plus one-cycle press/release pulses for the downstream mux and datapath labs.

Parameters:
- `clk_mhz`, 50: clock frequency in MHz, used only to derive the `settle_cycles` default.
- `w_key`, 4: number of independent input bits.
- `debounce_ms`, 10: debounce window in milliseconds.
- `settle_cycles`, `clk_mhz * 1000 * debounce_ms`: consecutive stable cycles required before a level change is accepted. Must be ≥ 1. Benches override it with a small value.
- `active_low`, 1: when 1, raw input 0 means "pressed" and the block inverts before synchronising.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `raw`, in, `w_key`: asynchronous board inputs.
- `level`, out, `w_key`: debounced, active-high state (1 = pressed).
- `pressed`, out, `w_key`: one-cycle pulse on a debounced 0→1 transition.
- `released`, out, `w_key`: one-cycle pulse on a debounced 1→0 transition.

Behaviour:
- Clock and reset are fixed: one clock, `clk`; reset `rst` is synchronous and active-high. All state is updated only on the rising edge of `clk`.
- **Reset.**
  - While `rst` = 1 at an edge, every flop clears: `sync1`, `sync2`, `level`, `pressed` and `released` go to 0, and every counter goes to 0.
  - A reset arriving mid-count abandons the count; no pulse is emitted.
  - Outputs are 0 on the first cycle after reset.
- **Polarity.** `norm = active_low ? ~raw : raw`, applied combinationally before the first flop.
- **Synchroniser.** Per bit, two flops: `sync1 <= norm`, `sync2 <= sync1`. No logic sits between them.
- **Per-bit debounce counter.**
  - Width is `$clog2(settle_cycles+1)`, minimum 1 bit.
  - At each edge (not in reset):
    - If `sync2 != level` and `cnt == settle_cycles-1`: `level <= sync2`, `cnt <= 0`, and set `pressed` (if `sync2` = 1) or `released` (if `sync2` = 0) for exactly one cycle.
    - If `sync2 != level` and `cnt < settle_cycles-1`: `cnt <= cnt+1`.
    - If `sync2 == level`: `cnt <= 0`. Any glitch shorter than `settle_cycles` therefore restarts the window.
  - The counter saturates by construction and never wraps.
- **Pulses.** `pressed` and `released` are registered. They are 0 in every cycle where the condition above does not fire, and are never both 1 for the same bit.
- **Latency.**
  - Suppose `raw` changes and is held stable before edge E0.
  - `level` flips, and the pulse asserts, at edge E0 + 1 + `settle_cycles`.
  - With `settle_cycles` = 1, that is edge E0+2.
- **Independence.** Bits are fully independent. Simultaneous changes on several bits produce simultaneous pulses.
- **Held input.** A level held indefinitely produces exactly one pulse.
- **Bounce.** Alternating `raw` faster than `settle_cycles` never changes `level`.

Decomposition:
- Package `key_debounce_pkg`:
  - function `settle_from_ms(clk_mhz, ms)`;
  - localparam for the minimum counter width.
- Sub-module `debounce_bit`:
  - one channel: synchroniser, counter, level, pulse flops;
  - parameters `settle_cycles` and `active_low`;
  - instantiated `w_key` times in a generate loop.
- The top level contains only the generate loop and port wiring.

Test Plan (`w_key`=4, `settle_cycles`=4, `active_low`=1, `raw` idle = 4'b1111):
- **Reset.** Hold `rst` 3 cycles with `raw`=4'b0000, release. Required: `level`/`pressed`/`released` = 0 in the first cycle after release. Then `level[3:0]` = 4'b1111 at edge 1+4 after release, with `pressed` = 4'b1111 for exactly one cycle.
- **Clean press.** From idle, set `raw[0]`=0 before edge E0 and hold. Required:
  - `level[0]` rises and `pressed[0]` = 1 at edge E0+5 only;
  - `released` stays 0;
  - other bits stay 0.
- **Bounce rejection.** Toggle `raw[1]` 1,0,1,0,… every 3 cycles for 30 cycles, then hold 1. Required: `level[1]` = 0 throughout, no pulses on bit 1.
- **Release.** After a clean press of bit 2, set `raw[2]`=1 and hold. Required: `level[2]` falls and `released[2]` = 1 for one cycle, 5 edges after the change.
- **Simultaneous / independent.** Drive `raw` = 4'b0101 (bits 1, 3 pressed) in one cycle. Required: `pressed` = 4'b1010 in a single cycle and `level` = 4'b1010. Bits 0 and 2 are unaffected.
- **Reset mid-count.** Press bit 0 and assert `rst` for 1 cycle 3 edges later while continuing to hold `raw[0]`=0. Required:
  - no pulse before reset;
  - after release, a fresh full latency of 5 edges;
  - exactly one `pressed[0]`.
